// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO capture logic that wraps the
// combinational divider (and later the multiplier path).
//   HILO_W        : architectural width of HI, LO and the operands
//   HILO_DZ_QUOT  : quotient reported when the divisor is zero
//   hilo_state_e  : capture FSM states
package hilo_pkg;

    localparam int HILO_W = 32;

    localparam logic [HILO_W-1:0] HILO_DZ_QUOT = 32'hFFFF_FFFF;

    typedef enum logic {
        HILO_IDLE   = 1'b0,
        HILO_SETTLE = 1'b1
    } hilo_state_e;

endpackage

// File: rtl/mc_settle_counter.sv
// Multicycle settle counter: a load/decrement down-counter with a zero
// flag. It is used to time how long a combinational arithmetic path is
// given to settle before its result is captured.
// Ports:
//   clk      in  : clock, rising edge
//   reset    in  : synchronous active-high reset (count -> 0)
//   load     in  : load load_val (takes priority over dec)
//   load_val in  : value to load
//   dec      in  : decrement by one; saturates at zero
//   zero     out : count is zero
module mc_settle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load wins over a decrement, and a decrement at zero
    // holds so the counter never wraps around.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/hilo_divide_capture.sv
// Capture stage around the combinational 32-bit signed divider. A start
// latches the operands onto the divider inputs, waits SETTLE_CYCLES for
// the divider to settle, then captures {remainder, quotient} into HI/LO.
// A zero divisor bypasses the divider and completes in one cycle. In
// IDLE, mthi/mtlo write HI/LO directly.
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   start                : divide request, sampled only in IDLE
//   dividend, divisor    : signed operands, sampled with start
//   div_a, div_b         : registered operands driving the divider
//   div_result           : divider output {remainder, quotient}
//   mthi, mtlo, wdata    : direct HI/LO writes (IDLE only)
//   hi, lo               : HI (remainder) and LO (quotient) registers
//   busy                 : divide in progress
//   done                 : one-cycle completion pulse, HI/LO valid with it
//   dz                   : last completed divide had a zero divisor
module hilo_divide_capture
    import hilo_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [HILO_W-1:0]   dividend,
    input  logic [HILO_W-1:0]   divisor,
    output logic [HILO_W-1:0]   div_a,
    output logic [HILO_W-1:0]   div_b,
    input  logic [2*HILO_W-1:0] div_result,
    input  logic                mthi,
    input  logic                mtlo,
    input  logic [HILO_W-1:0]   wdata,
    output logic [HILO_W-1:0]   hi,
    output logic [HILO_W-1:0]   lo,
    output logic                busy,
    output logic                done,
    output logic                dz
);

    // Counter reload value: the capture happens on the edge where the
    // counter has already reached zero, so load one less than the window.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    hilo_state_e       state_q, state_d;
    logic [HILO_W-1:0] div_a_q, div_a_d;
    logic [HILO_W-1:0] div_b_q, div_b_d;
    logic [HILO_W-1:0] hi_q, hi_d;
    logic [HILO_W-1:0] lo_q, lo_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;

    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    mc_settle_counter #(
        .W (4)
    ) u_settle_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state and register updates. In IDLE a start takes priority
    // over move writes; in SETTLE every request is ignored because the
    // pipeline is stalled on busy.
    always_comb begin
        state_d  = state_q;
        div_a_d  = div_a_q;
        div_b_d  = div_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        case (state_q)
            HILO_IDLE: begin
                if (start) begin
                    div_a_d = dividend;
                    div_b_d = divisor;
                    if (divisor != '0) begin
                        cnt_load = 1'b1;
                        state_d  = HILO_SETTLE;
                    end else begin
                        // Zero divisor: skip the divider entirely.
                        hi_d   = dividend;
                        lo_d   = HILO_DZ_QUOT;
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                    end
                end else begin
                    if (mthi) begin
                        hi_d = wdata;
                    end
                    if (mtlo) begin
                        lo_d = wdata;
                    end
                end
            end

            HILO_SETTLE: begin
                if (cnt_zero) begin
                    hi_d    = div_result[2*HILO_W-1:HILO_W];
                    lo_d    = div_result[HILO_W-1:0];
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = HILO_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            default: begin
                state_d = HILO_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HILO_IDLE;
            div_a_q <= '0;
            div_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_a_q <= div_a_d;
            div_b_q <= div_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign div_a = div_a_q;
    assign div_b = div_b_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign done  = done_q;
    assign dz    = dz_q;
    assign busy  = (state_q == HILO_SETTLE);

endmodule

// File: tb/tb_hilo_divide_capture.sv
// Testbench for hilo_divide_capture. A behavioural divider sits on the
// div_a/div_b -> div_result path; expected HI/LO/dz come from the
// operands the bench applied and plain signed arithmetic, and expected
// busy/done follow the documented cycle timeline.
module tb_hilo_divide_capture;

    localparam int S = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [63:0] div_result;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        dz;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_dz;

    int total;
    int bad;

    hilo_divide_capture #(
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_result (div_result),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .wdata      (wdata),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .dz         (dz)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational divider: {remainder, quotient}.
    always_comb begin
        div_result = '0;
        if (div_b != '0) begin
            div_result = {32'($signed(div_a) % $signed(div_b)),
                          32'($signed(div_a) / $signed(div_b))};
        end
    end

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare every architectural output against the model.
    task automatic checkOutput(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
        chk({tag, "_dz"}, 32'(dz), 32'(m_dz));
    endtask

    // Reference result of one divide, straight from the operand values.
    task automatic modelDivide(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            m_hi = a;
            m_lo = 32'hFFFF_FFFF;
            m_dz = 1'b1;
        end else begin
            m_hi = 32'(sa % sb);
            m_lo = 32'(sa / sb);
            m_dz = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then release.
    task automatic applyStimulus(input logic st, input logic [31:0] a, input logic [31:0] b,
                                 input logic wh, input logic wl, input logic [31:0] wd);
        start    = st;
        dividend = a;
        divisor  = b;
        mthi     = wh;
        mtlo     = wl;
        wdata    = wd;
        tick();
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
    endtask

    // Full divide along the expected timeline; returns in the done cycle.
    task automatic runDivide(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic wl, input logic [31:0] wd);
        applyStimulus(1'b1, a, b, 1'b0, wl, wd);
        if (b != 32'd0) begin
            for (int c = 1; c <= S; c++) begin
                checkOutput({tag, "_settle"}, 1'b1, 1'b0);
                tick();
            end
        end
        modelDivide(a, b);
        checkOutput({tag, "_done"}, 1'b0, 1'b1);
    endtask

    // Divide with a disturbance in cycle 2: mode 0 a second start (8/2),
    // mode 1 an mtlo. Either must be ignored; exactly one done expected.
    task automatic runDisturbed(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input int mode);
        int dones;
        dones = 0;
        applyStimulus(1'b1, a, b, 1'b0, 1'b0, 32'd0);
        for (int c = 1; c <= S + 3; c++) begin
            if (c == S + 1) begin
                modelDivide(a, b);
            end
            checkOutput(tag, (c <= S), (c == S + 1));
            if (c <= S) begin
                chk({tag, "_div_a"}, div_a, a);
            end
            if (done) begin
                dones++;
            end
            if (c == 2 && mode == 0) begin
                applyStimulus(1'b1, 32'd8, 32'd2, 1'b0, 1'b0, 32'd0);
            end else if (c == 2) begin
                applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hBAD0_BAD0);
            end else begin
                tick();
            end
        end
        chk({tag, "_done_count"}, 32'(dones), 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        mthi     = 1'b0;
        mtlo     = 1'b0;
        wdata    = '0;
        m_hi     = '0;
        m_lo     = '0;
        m_dz     = 1'b0;

        // Reset state.
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset", 1'b0, 1'b0);
        chk("reset_div_a", div_a, 32'd0);
        chk("reset_div_b", div_b, 32'd0);

        // Nonzero divide 100 / 7.
        $display("[TB] nonzero divide");
        runDivide("div100_7", 32'd100, 32'd7, 1'b0, 32'd0);
        chk("div100_7_hi_const", hi, 32'd2);
        chk("div100_7_lo_const", lo, 32'd14);
        tick();
        checkOutput("after_done", 1'b0, 1'b0);

        // Zero divisor, then a divide that clears dz.
        $display("[TB] zero divisor");
        runDivide("div55_0", 32'd55, 32'd0, 1'b0, 32'd0);
        chk("div55_0_lo_const", lo, 32'hFFFF_FFFF);
        tick();
        checkOutput("after_dz", 1'b0, 1'b0);
        runDivide("div9_3", 32'd9, 32'd3, 1'b0, 32'd0);
        chk("div9_3_lo_const", lo, 32'd3);
        tick();

        // Start while busy is ignored.
        $display("[TB] start while busy");
        runDisturbed("busy_start", 32'd100, 32'd7, 0);
        chk("busy_start_lo_const", lo, 32'd14);

        // Random back-to-back divides, some with zero divisors.
        $display("[TB] random back-to-back");
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = 32'($urandom_range(2, 5000));
            if ($urandom_range(0, 1) == 1) begin
                rb = -rb;
            end
            if ($urandom_range(0, 4) == 0) begin
                rb = 32'd0;
            end
            runDivide("rand", ra, rb, 1'b0, 32'd0);
        end
        tick();
        checkOutput("rand_idle", 1'b0, 1'b0);

        // Move writes.
        $display("[TB] move writes");
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        m_hi = 32'hDEAD_BEEF;
        checkOutput("mthi", 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0000_1234);
        m_hi = 32'h0000_1234;
        m_lo = 32'h0000_1234;
        checkOutput("mthi_mtlo", 1'b0, 1'b0);
        runDisturbed("settle_mtlo", 32'hFFFF_FF9C, 32'd7, 1);
        tick();
        runDivide("start_mtlo", 32'd77, 32'd5, 1'b1, 32'h5555_5555);
        tick();

        // Reset in cycle 2 of a divide.
        $display("[TB] reset mid-divide");
        applyStimulus(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
        checkOutput("rst_c1", 1'b1, 1'b0);
        tick();
        checkOutput("rst_c2", 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        checkOutput("rst_now", 1'b0, 1'b0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_div_b", div_b, 32'd0);
        for (int c = 0; c < S + 2; c++) begin
            tick();
            checkOutput("rst_after", 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
